seq_multiplier: RTL and testbench

- Iterative shift-add unsigned multiplier with a start/done handshake. It is the inverse-operation companion of the restoring divider in the arithmetic datapath.
- Retires one multiplier bit per clock and produces a 2*WIDTH-bit product after exactly WIDTH iteration cycles.
- Used alongside the divider to rescale baud/clock ratios and frame counts before they are loaded into the UART timing logic.

---
 rtl/arith_pkg.sv | 21 ++
 rtl/seq_mul_core.sv | 62 ++++++
 rtl/seq_multiplier.sv | 100 ++++++++++
 tb/tb_seq_multiplier.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath constants: FSM state encoding, default operand width,
// and the counter-width helper used by the iterative multiplier and divider.
package arith_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int unsigned ARITH_WIDTH = 16;

   // Bits needed to hold values 0 .. value-1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((64'd1 << result) < 64'(value)) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/seq_mul_core.sv
// Shift-add datapath: accumulator, multiplier shift register and iteration counter.
// One multiplier bit is retired per step; p_next_o is the working register after the step.
module seq_mul_core
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = ARITH_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               step_i,
   input  logic [WIDTH-1:0]   mcand_i,
   input  logic [WIDTH-1:0]   mplr_i,
   output logic               last_o,
   output logic [2*WIDTH-1:0] p_next_o
);

   localparam int unsigned CntW = clog2(WIDTH + 1);

   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplr_q, mplr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   always_comb begin
      sum      = acc_q + (mplr_q[0] ? {1'b0, mcand_q} : '0);
      // Low 2*WIDTH bits of {sum, mplr} >> 1; the top bit is always zero after the shift.
      p_next_o = {sum[WIDTH:1], sum[0], mplr_q[WIDTH-1:1]};
      last_o   = (cnt_q == CntW'(1));

      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         acc_d   = '0;
         mcand_d = mcand_i;
         mplr_d  = mplr_i;
         cnt_d   = CntW'(WIDTH);
      end else if (step_i) begin
         acc_d  = {1'b0, sum[WIDTH:1]};
         mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
         cnt_d  = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative multiplier top: start/done handshake FSM, result register and optional
// two's-complement wrapper enabled by defining SEQ_MUL_SIGNED_EN.
module seq_multiplier
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = ARITH_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   logic [1:0]         state_q, state_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic [2*WIDTH-1:0] p_next;
   logic [2*WIDTH-1:0] result;
   logic [WIDTH-1:0]   op_a, op_b;
   logic               accept;
   logic               step;
   logic               last;

   assign ready   = (state_q != ST_RUN);
   assign busy    = (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);
   assign product = product_q;
   assign accept  = ready & start;
   assign step    = busy;

`ifdef SEQ_MUL_SIGNED_EN
   logic neg_q, neg_d;

   // Unary minus of the most-negative value wraps to itself, which is the right magnitude.
   assign op_a   = multiplicand[WIDTH-1] ? -multiplicand : multiplicand;
   assign op_b   = multiplier[WIDTH-1] ? -multiplier : multiplier;
   assign neg_d  = accept ? (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]) : neg_q;
   assign result = neg_q ? -p_next : p_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_q <= 1'b0;
      end else begin
         neg_q <= neg_d;
      end
   end
`else
   assign op_a   = multiplicand;
   assign op_b   = multiplier;
   assign result = p_next;
`endif

   seq_mul_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (accept),
      .step_i   (step),
      .mcand_i  (op_a),
      .mplr_i   (op_b),
      .last_o   (last),
      .p_next_o (p_next)
   );

   always_comb begin
      state_d   = state_q;
      product_d = product_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (last) begin
               state_d   = ST_DONE;
               product_d = result;
            end
         end
         ST_DONE: begin
            state_d = accept ? ST_RUN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         product_q <= product_d;
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed, table-driven bench for seq_multiplier (WIDTH=16) with hand-written
// sequences for start-during-RUN, back-to-back and mid-RUN reset.
module tb_seq_multiplier;

   localparam int unsigned W = 16;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   multiplicand;
   logic [W-1:0]   multiplier;
   logic           ready;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   int n_cmp;
   int n_bad;

   typedef struct {
      string        name;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [31:0]  p;
   } vec_t;

   vec_t vecs[$];

   seq_multiplier #(
      .WIDTH (W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .ready        (ready),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Launch one operation and follow it to done; returns latency (edges after the
   // accepting edge), busy cycles, the product sampled mid-run and at done.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cnt,
                         output logic [31:0] mid_prod, output logic [31:0] prod);
      @(negedge clk);
      start        = 1'b1;
      multiplicand = a;
      multiplier   = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      lat      = 0;
      busy_cnt = 0;
      mid_prod = product;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         if (lat == 8) mid_prod = product;
         @(posedge clk);
         #1;
         lat++;
      end
      prod = product;
   endtask

   initial begin
      int          lat, bcnt, cnt;
      logic [31:0] mid, prod, prev;
      logic        seen;

      n_cmp = 0;
      n_bad = 0;
      start = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      rst_n = 1'b0;

      vecs.push_back('{"3x5",   16'h0003, 16'h0005, 32'h0000000F});
      vecs.push_back('{"0x1234", 16'h0000, 16'h1234, 32'h00000000});
      vecs.push_back('{"7x9",   16'h0007, 16'h0009, 32'h0000003F});
`ifdef SEQ_MUL_SIGNED_EN
      vecs.push_back('{"m3x5",  16'hFFFD, 16'h0005, 32'hFFFFFFF1});
      vecs.push_back('{"minxmin", 16'h8000, 16'h8000, 32'h40000000});
      vecs.push_back('{"minx1", 16'h8000, 16'h0001, 32'hFFFF8000});
      vecs.push_back('{"m1xm1", 16'hFFFF, 16'hFFFF, 32'h00000001});
`else
      vecs.push_back('{"ffffxffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001});
      vecs.push_back('{"8000x8000", 16'h8000, 16'h8000, 32'h40000000});
`endif
      vecs.push_back('{"0x1234b", 16'h0000, 16'h1234, 32'h00000000});

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_product", 64'(product), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      prev = 32'h0;
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, lat, bcnt, mid, prod);
         check({vecs[i].name, "_lat"}, 64'(lat), 64'd16);
         check({vecs[i].name, "_busy"}, 64'(bcnt), 64'd16);
         check({vecs[i].name, "_hold"}, 64'(mid), 64'(prev));
         check({vecs[i].name, "_prod"}, 64'(prod), 64'(vecs[i].p));
         check({vecs[i].name, "_ready"}, 64'(ready), 64'd1);
         @(posedge clk);
         #1;
         check({vecs[i].name, "_pulse"}, 64'(done), 64'd0);
         prev = vecs[i].p;
      end

      // start re-asserted during RUN is ignored
      @(negedge clk);
      start = 1'b1;
      multiplicand = 16'h0007;
      multiplier   = 16'h0009;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      multiplicand = 16'h0002;
      multiplier   = 16'h0002;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b0;
      lat = 7;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("ign_lat", 64'(lat), 64'd16);
      check("ign_prod", 64'(product), 64'h3F);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      check("ign_no_second_done", 64'(seen), 64'd0);

      // back-to-back: start held in the DONE cycle
      run_op(16'h0006, 16'h0007, lat, bcnt, mid, prod);
      check("b2b_first_prod", 64'(prod), 64'h2A);
      start = 1'b1;
      multiplicand = 16'h0010;
      multiplier   = 16'h0010;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b_busy", 64'(busy), 64'd1);
      cnt = 1;
      while (!done && cnt < 40) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      check("b2b_gap", 64'(cnt), 64'd17);
      check("b2b_prod", 64'(product), 64'h100);

      // reset 5 cycles into RUN aborts
      repeat (2) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      multiplicand = 16'h00FF;
      multiplier   = 16'h00FF;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_product", 64'(product), 64'd0);
      check("abort_ready", 64'(ready), 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      check("abort_no_done", 64'(seen), 64'd0);
      run_op(16'h0002, 16'h0003, lat, bcnt, mid, prod);
      check("post_lat", 64'(lat), 64'd16);
      check("post_hold", 64'(mid), 64'd0);
      check("post_prod", 64'(prod), 64'd6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
